button_cmd_arbiter: RTL and testbench



---
 rtl/button_cmd_arbiter.sv | 150 +++++++++++++++
 tb/tb_button_cmd_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/button_cmd_arbiter.sv
// button_cmd_arbiter: latches single-cycle button pulses as pending events and
// issues them one at a time, round-robin, to a configuration sequencer over a
// valid/ready command handshake, then enforces a lockout after each completion.
// Optional build macro BTN_OVERRUN_EN adds a sticky per-channel overrun output
// that flags events dropped because the channel was already pending.
module button_cmd_arbiter #(
  parameter int N_BTN          = 4,
  parameter int LOCKOUT_CYCLES = 2048,
  parameter int ID_W           = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_pulse,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [ID_W-1:0]  cmd_id,
  output logic [N_BTN-1:0] cmd_onehot,
  input  logic             cmd_done,
  output logic             busy,
`ifdef BTN_OVERRUN_EN
  output logic [N_BTN-1:0] overrun,
`endif
  output logic [N_BTN-1:0] pending
);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, LOCKOUT} state_t;

  // Counter only ever reaches LOCKOUT_CYCLES-1, so it can never wrap.
  localparam int CNT_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_BTN - 1);

  state_t             state_q, state_d;
  logic [N_BTN-1:0]   pending_q, pending_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [N_BTN-1:0]   onehot_q, onehot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef BTN_OVERRUN_EN
  logic [N_BTN-1:0]   overrun_q, overrun_d;
`endif

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [N_BTN-1:0]   grant_onehot;
  int                 cand;

  // State register: all flops, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      last_q    <= LAST_RST;
      id_q      <= '0;
      onehot_q  <= '0;
      cnt_q     <= '0;
`ifdef BTN_OVERRUN_EN
      overrun_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      id_q      <= id_d;
      onehot_q  <= onehot_d;
      cnt_q     <= cnt_d;
`ifdef BTN_OVERRUN_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  // Round-robin search: first pending bit from last+1 upward, with wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_BTN) cand = cand - N_BTN;
      if (!grant_found && pending_q[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
    grant_onehot = grant_found ? (N_BTN'(1) << grant_idx) : '0;
  end

  // Next-state logic: FSM transitions, pending latch, grant registers, lockout.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    onehot_d = onehot_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          id_d     = grant_idx;
          onehot_d = grant_onehot;
          last_d   = grant_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) state_d = EXEC;
      end
      EXEC: begin
        if (cmd_done) begin
          cnt_d   = '0;
          state_d = (LOCKOUT_CYCLES == 0) ? IDLE : LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant only happens in IDLE; a pulse on the granted channel re-queues it.
    pending_d = (pending_q & ~((state_q == IDLE) ? grant_onehot : '0)) | btn_pulse;
`ifdef BTN_OVERRUN_EN
    overrun_d = overrun_q |
                (btn_pulse & pending_q & ~((state_q == IDLE) ? grant_onehot : '0));
`endif
  end

  // Output decode from registered state; onehot is masked outside ISSUE.
  always_comb begin
    cmd_valid  = (state_q == ISSUE);
    cmd_id     = id_q;
    cmd_onehot = (state_q == ISSUE) ? onehot_q : '0;
    busy       = (state_q != IDLE);
    pending    = pending_q;
`ifdef BTN_OVERRUN_EN
    overrun    = overrun_q;
`endif
  end

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Directed self-checking bench for button_cmd_arbiter (N_BTN=4, LOCKOUT_CYCLES=8).
module tb_button_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_pulse;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_id;
  logic [3:0] cmd_onehot;
  logic       cmd_done;
  logic       busy;
  logic [3:0] pending;
`ifdef BTN_OVERRUN_EN
  logic [3:0] overrun;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int gap;
  int stable;

  button_cmd_arbiter #(.N_BTN(4), .LOCKOUT_CYCLES(8), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_pulse(btn_pulse),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_onehot(cmd_onehot), .cmd_done(cmd_done), .busy(busy),
`ifdef BTN_OVERRUN_EN
    .overrun(overrun),
`endif
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count clocks until cmd_valid rises, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (cmd_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_done();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; btn_pulse = '0; cmd_ready = 1'b1; cmd_done = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_id", cmd_id, 0);
    check("rst_onehot", cmd_onehot, 0);
`ifdef BTN_OVERRUN_EN
    check("rst_overrun", overrun, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Single event on channel 2.
    btn_pulse = 4'b0100;
    tick();
    btn_pulse = '0;
    check("single_pending", pending, 4'b0100);
    check("single_valid_early", cmd_valid, 0);
    tick();
    check("single_valid", cmd_valid, 1);
    check("single_id", cmd_id, 2);
    check("single_onehot", cmd_onehot, 4'b0100);
    check("single_pending_clr", pending, 0);
    tick();
    check("single_accept_valid", cmd_valid, 0);
    check("single_accept_onehot", cmd_onehot, 0);
    check("single_exec_busy", busy, 1);
    pulse_done();
    for (int i = 0; i < 7; i++) tick();
    check("single_lockout_busy", busy, 1);
    tick();
    check("single_idle", busy, 0);

    // Round-robin from reset: all four channels at once.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    btn_pulse = 4'b1111;
    tick();
    btn_pulse = '0;
    check("rr_pending", pending, 4'b1111);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("rr_valid", cmd_valid, 1);
      check("rr_id", cmd_id, k);
      check("rr_onehot", cmd_onehot, 4'b0001 << k);
      tick();                 // accept
      tick(); tick();
      pulse_done();           // done 3 cycles after accept
      if (k < 3) begin
        wait_valid(gap);
        check("rr_gap", gap, 9);
      end
    end
    for (int i = 0; i < 8; i++) tick();
    check("rr_end_busy", busy, 0);
    check("rr_end_pending", pending, 0);

    // Backpressure on channel 1 (last=3, so search order 0,1,...).
    cmd_ready = 1'b0;
    btn_pulse = 4'b0010;
    tick();
    btn_pulse = '0;
    tick();
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) cmd_done = 1'b1;   // done outside EXEC is ignored
      if (cmd_valid === 1'b1 && cmd_id === 2'd1 && cmd_onehot === 4'b0010) stable++;
      tick();
      cmd_done = 1'b0;
    end
    check("bp_stable_cycles", stable, 20);
    check("bp_still_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    tick();
    check("bp_accepted", cmd_valid, 0);
    check("bp_exec_busy", busy, 1);

    // Overrun: channel 1 pulsed twice while busy.
    btn_pulse = 4'b0010;
    tick();
    tick();
    btn_pulse = '0;
    check("ovr_pending", pending, 4'b0010);
`ifdef BTN_OVERRUN_EN
    check("ovr_flag", overrun, 4'b0010);
`endif
    pulse_done();
    wait_valid(gap);
    check("ovr_gap", gap, 9);
    check("ovr_id", cmd_id, 1);
    check("ovr_pending_clr", pending, 0);
    tick();
    tick();
    pulse_done();
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid === 1'b1) stable++;
      tick();
    end
    check("ovr_single_cmd", stable, 0);
    check("ovr_idle", busy, 0);

    // Same-cycle set/clear on channel 0.
    btn_pulse = 4'b0001;
    tick();
    check("sc_pending", pending, 4'b0001);
    tick();                    // grant edge with pulse still high
    btn_pulse = '0;
    check("sc_valid", cmd_valid, 1);
    check("sc_id", cmd_id, 0);
    check("sc_requeued", pending, 4'b0001);
    tick();
    tick();
    pulse_done();
    wait_valid(gap);
    check("sc_gap", gap, 9);
    check("sc_second_id", cmd_id, 0);
    check("sc_second_pending", pending, 0);
    tick();
    check("sc_exec", busy, 1);

    // Reset mid-EXEC, with channel 3 pending.
    btn_pulse = 4'b1000;
    tick();
    btn_pulse = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rme_busy", busy, 0);
    check("rme_pending", pending, 0);
    check("rme_valid", cmd_valid, 0);
    pulse_done();
    tick(); tick();
    check("rme_done_ignored_busy", busy, 0);
    check("rme_done_ignored_valid", cmd_valid, 0);
`ifdef BTN_OVERRUN_EN
    check("rme_overrun", overrun, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
